// File: rtl/mem_sweep_ctrl.sv
// Sequencer/arbiter in front of one single-clock BRAM: bulk FILL, checksum SCAN,
// and direct single-user access while idle.
module mem_sweep_ctrl #(
   parameter int unsigned WID_MEM   = 9,
   parameter int unsigned DEPTH_MEM = 2048
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               op,
   input  logic [WID_MEM-1:0] fill_value,
   output logic               busy,
   output logic               done,
   output logic [31:0]        checksum,
   input  logic               usr_req,
   input  logic               usr_we,
   input  logic [31:0]        usr_addr,
   input  logic [WID_MEM-1:0] usr_wdata,
   output logic               usr_gnt,
   output logic [WID_MEM-1:0] usr_rdata,
   output logic               usr_rvalid,
   output logic               usr_addr_err,
   output logic [31:0]        mem_raddr,
   output logic [31:0]        mem_waddr,
   output logic               mem_we,
   output logic [WID_MEM-1:0] mem_din,
   input  logic [WID_MEM-1:0] mem_dout
);

   localparam int unsigned    CNT_W    = (DEPTH_MEM > 1) ? $clog2(DEPTH_MEM) : 1;
   localparam int unsigned    ADDR_W   = 32;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEPTH_MEM - 1);
   localparam logic [ADDR_W-1:0] ADDR_END = ADDR_W'(DEPTH_MEM);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_SCAN  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [WID_MEM-1:0] r_fill;
   logic [31:0]        r_checksum;
   logic               r_done;
   logic               r_rvalid;
   logic               r_addr_err;
   logic               r_rd_pend;

   logic               w_idle;
   logic               w_usr_go;
   logic               w_in_range;

   // A user access is only taken in IDLE when no command launches this cycle.
   assign w_idle     = (r_state == ST_IDLE);
   assign w_usr_go   = w_idle & ~start & usr_req;
   assign w_in_range = (usr_addr < ADDR_END);

   assign busy         = ~w_idle;
   assign done         = r_done;
   assign checksum     = r_checksum;
   assign usr_rvalid   = r_rvalid;
   assign usr_addr_err = r_addr_err;
   assign usr_rdata    = r_rvalid ? mem_dout : '0;
   assign usr_gnt      = w_usr_go & reset;

   // Memory port mux: sweep counter while busy, user port while idle.
   always_comb begin
      mem_raddr = '0;
      mem_waddr = '0;
      mem_we    = 1'b0;
      mem_din   = '0;
      if (reset) begin
         case (r_state)
            ST_FILL: begin
               mem_waddr = ADDR_W'(r_cnt);
               mem_we    = 1'b1;
               mem_din   = r_fill;
            end
            ST_SCAN: begin
               mem_raddr = ADDR_W'(r_cnt);
            end
            ST_IDLE: begin
               if (w_usr_go) begin
                  mem_raddr = usr_addr;
                  mem_waddr = usr_addr;
                  mem_din   = usr_wdata;
                  mem_we    = usr_we & w_in_range;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Sequencer, checksum accumulator and user response flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_fill     <= '0;
         r_checksum <= '0;
         r_done     <= 1'b0;
         r_rvalid   <= 1'b0;
         r_addr_err <= 1'b0;
         r_rd_pend  <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_rvalid   <= w_usr_go & ~usr_we & w_in_range;
         r_addr_err <= w_usr_go & ~w_in_range;
         r_rd_pend  <= (r_state == ST_SCAN);

         // Read data lands one cycle after its SCAN address was issued.
         if (r_rd_pend) begin
            r_checksum <= r_checksum + 32'(mem_dout);
         end

         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_cnt <= '0;
                  if (op) begin
                     r_fill  <= fill_value;
                     r_state <= ST_FILL;
                  end else begin
                     r_checksum <= '0;
                     r_state    <= ST_SCAN;
                  end
               end
            end
            ST_FILL: begin
               if (r_cnt == CNT_LAST) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_SCAN: begin
               if (r_cnt == CNT_LAST) begin
                  r_state <= ST_DRAIN;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_DRAIN: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b1;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_sweep_ctrl.md
Name: mem_sweep_ctrl

Overview:
Sequencer and arbiter in front of one single-clock BRAM instance: 32-bit raddr/waddr, 1-cycle registered read.
- Runs two bulk operations over the whole array: FILL writes a constant to every word; SCAN reads every word and returns a 32-bit additive checksum.
- When idle, grants a single user port direct read/write access to the memory.
- Lets the reinit flow verify or clear BRAM contents without touching the bitstream.

Parameters:
WID_MEM, 9, memory word width in bits
DEPTH_MEM, 2048, number of memory words; valid addresses 0..DEPTH_MEM-1

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
start  input  1  1-cycle pulse that launches the operation selected by op
op  input  1  0 = SCAN (checksum), 1 = FILL
fill_value  input  WID_MEM  word written during FILL, sampled at start
busy  output  1  high while FILL/SCAN is in progress
done  output  1  1-cycle pulse at operation end
checksum  output  32  SCAN result; holds value until next SCAN start
usr_req  input  1  user access request (level, per cycle)
usr_we  input  1  1 = write, 0 = read
usr_addr  input  32  user address
usr_wdata  input  WID_MEM  user write data
usr_gnt  output  1  combinational; request accepted this cycle
usr_rdata  output  WID_MEM  read data, valid when usr_rvalid is high
usr_rvalid  output  1  high the cycle after a granted in-range read
usr_addr_err  output  1  1-cycle pulse (registered) for a granted out-of-range access
mem_raddr  output  32  memory read address
mem_waddr  output  32  memory write address
mem_we  output  1  memory write enable
mem_din  output  WID_MEM  memory write data
mem_dout  input  WID_MEM  memory read data (1-cycle latency)

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; busy, done, usr_rvalid, usr_addr_err, mem_we = 0.
  - checksum, addresses, mem_din = 0.
  - Reset mid-operation aborts immediately; memory contents are left partial; no done pulse.
- States and transitions:
  - IDLE: start && op=1 -> FILL; start && op=0 -> SCAN with checksum cleared to 0.
  - FILL: mem_we=1, mem_waddr=cnt, mem_din=latched fill_value, cnt 0..DEPTH_MEM-1 one word per cycle. After cnt=DEPTH_MEM-1 -> IDLE with done=1 for that next cycle. Total DEPTH_MEM busy cycles.
  - SCAN: mem_raddr=cnt, mem_we=0; cnt 0..DEPTH_MEM-1, then -> DRAIN.
  - DRAIN: captures the last word (one cycle), then -> IDLE with done=1. Total DEPTH_MEM+1 busy cycles.
- Checksum arithmetic:
  - Each word is accumulated the cycle after its address is issued: checksum += zero-extended mem_dout, mod 2^32.
  - Checksum is final when done pulses; not updated outside SCAN/DRAIN.
- Command handling:
  - busy = state != IDLE; done is never high together with busy.
  - start while busy: ignored, no effect.
  - start and usr_req in the same IDLE cycle: start wins, usr_gnt=0.
- User port (IDLE only, no start this cycle):
  - usr_gnt = usr_req. mem_raddr = mem_waddr = usr_addr[31:0]; mem_din = usr_wdata; mem_we = usr_we.
  - usr_rvalid rises the next cycle for a read, with usr_rdata = mem_dout.
  - Out-of-range (usr_addr >= DEPTH_MEM): still granted, mem_we forced 0, no rvalid, usr_addr_err pulses the next cycle.
  - While busy: usr_gnt=0; requester must hold usr_req until granted.
- Idle with no request: mem_we=0, addresses 0.
- Read-during-write to the same user address: read returns the old data (memory is read-first).

Test Plan:
- Reset values: hold reset=0 with random inputs -> busy=0, done=0, mem_we=0, checksum=0; release reset -> still idle, no spurious done.
- FILL then SCAN: start op=1 fill_value=0x1A5 -> busy for 2048 cycles, 2048 writes, done pulse. Then start op=0 -> done after 2049 busy cycles, checksum=0x000D2800.
- User access: idle, write addr 5 data 0x0FF (gnt=1, mem_we=1) -> read addr 5 -> usr_rvalid next cycle, usr_rdata=0x0FF. After FILL 0, write addr 7=0x1FF, then SCAN -> checksum=0x000001FF.
- Contention: during FILL, assert usr_req and a second start -> usr_gnt=0 throughout, start ignored; gnt=1 on the first idle cycle after done. Same-cycle start+usr_req in IDLE -> op launches, gnt=0.
- Out-of-range: usr write addr 2048 -> gnt=1, mem_we=0, usr_addr_err=1 next cycle, memory unchanged (verified by SCAN).
- Reset mid-FILL at cnt=100 -> busy=0 asynchronously, no done. New FILL 0x000 then SCAN -> checksum=0.
